conv_4_gray_arbiter: RTL and testbench

//  Shares one 4-bit binary->Gray converter among N_REQ requesters using round-robin arbitration.

---
 rtl/conv_4_gray_arbiter_pkg.sv | 12 +
 rtl/conv_4_gray_dataflow.sv | 9 +
 rtl/conv_4_gray_arbiter.sv | 125 ++++++++++++
 tb/tb_conv_4_gray_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_4_gray_arbiter_pkg.sv
// Shared constants for the Gray-converter arbiter: output-stage state encoding and word width.
package conv_4_gray_arbiter_pkg;

  localparam int GRAY_W        = 4;
  localparam int N_REQ_DEFAULT = 4;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/conv_4_gray_dataflow.sv
// Pure combinational 4-bit binary to Gray converter.
module conv_4_gray_dataflow (
  input  logic [3:0] bin_i,
  output logic [3:0] gray_o
);

  assign gray_o = {bin_i[3], bin_i[3] ^ bin_i[2], bin_i[2] ^ bin_i[1], bin_i[1] ^ bin_i[0]};

endmodule

// File: rtl/conv_4_gray_arbiter.sv
// Round-robin shared binary->Gray converter with a single-entry output stage.
// Optional macro CONV_4_GRAY_ARB_PARITY_EN adds out_par and req_mask.
module conv_4_gray_arbiter
  import conv_4_gray_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int ID_W  = 2,
  parameter int CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [GRAY_W*N_REQ-1:0] req_bin,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [GRAY_W-1:0]       out_gray,
  output logic [ID_W-1:0]         out_id,
  output logic [CNT_W-1:0]        xfer_cnt,
`ifdef CONV_4_GRAY_ARB_PARITY_EN
  output logic                    out_par,
  input  logic [N_REQ-1:0]        req_mask,
`endif
  output logic                    dbg_state
);

  // Handshake: a word moves when valid & ready are both high at a rising
  // edge; ready depends combinationally on valid, valid never waits on ready.

  out_state_e               state_q, state_d;
  logic [GRAY_W-1:0]        out_gray_q;
  logic [ID_W-1:0]          out_id_q;
  logic [ID_W-1:0]          last_gnt_q;
  logic [CNT_W-1:0]         xfer_cnt_q;
  logic [N_REQ-1:0]         elig;
  logic                     gnt_found;
  logic [ID_W-1:0]          gnt_idx;
  logic                     space;
  logic                     drain;
  logic                     accept;
  logic [GRAY_W-1:0]        sel_bin;
  logic [GRAY_W-1:0]        sel_gray;

`ifdef CONV_4_GRAY_ARB_PARITY_EN
  logic out_par_q;
  assign elig = req_valid & ~req_mask;
`else
  assign elig = req_valid;
`endif

  assign out_valid = (state_q == ST_FULL);
  assign drain     = out_valid & out_ready;
  assign space     = (state_q == ST_EMPTY) | drain;
  assign accept    = space & gnt_found & ~rst;

  // Search starts just after the last winner so every waiting requester
  // is reached within N_REQ grants.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!gnt_found && elig[(int'(last_gnt_q) + k) % N_REQ]) begin
        gnt_found = 1'b1;
        gnt_idx   = ID_W'((int'(last_gnt_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[gnt_idx] = 1'b1;
  end

  assign sel_bin = req_bin[int'(gnt_idx)*GRAY_W +: GRAY_W];

  conv_4_gray_dataflow u_conv (
    .bin_i  (sel_bin),
    .gray_o (sel_gray)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (accept) state_d = ST_FULL;
      ST_FULL:  if (drain && !accept) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_gray_q <= '0;
      out_id_q   <= '0;
      last_gnt_q <= ID_W'(N_REQ - 1);
    end else if (accept) begin
      out_gray_q <= sel_gray;
      out_id_q   <= gnt_idx;
      last_gnt_q <= gnt_idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        xfer_cnt_q <= '0;
    else if (drain) xfer_cnt_q <= xfer_cnt_q + CNT_W'(1);
  end

`ifdef CONV_4_GRAY_ARB_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         out_par_q <= 1'b0;
    else if (accept) out_par_q <= ^sel_gray;
  end
  assign out_par = out_par_q;
`endif

  assign out_gray  = out_gray_q;
  assign out_id    = out_id_q;
  assign xfer_cnt  = xfer_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_conv_4_gray_arbiter.sv
// Self-checking bench for conv_4_gray_arbiter: directed cases plus randomized traffic vs a behavioural model.
module tb_conv_4_gray_arbiter;

  localparam int N_REQ = 4;
  localparam int ID_W  = 2;
  localparam int CNT_W = 16;

  logic                 clk;
  logic                 rst;
  logic [N_REQ-1:0]     req_valid;
  logic [4*N_REQ-1:0]   req_bin;
  logic [N_REQ-1:0]     req_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [3:0]           out_gray;
  logic [ID_W-1:0]      out_id;
  logic [CNT_W-1:0]     xfer_cnt;
  logic                 dbg_state;
`ifdef CONV_4_GRAY_ARB_PARITY_EN
  logic                 out_par;
  logic [N_REQ-1:0]     req_mask;
`endif

  conv_4_gray_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_bin   (req_bin),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_gray  (out_gray),
    .out_id    (out_id),
    .xfer_cnt  (xfer_cnt),
`ifdef CONV_4_GRAY_ARB_PARITY_EN
    .out_par   (out_par),
    .req_mask  (req_mask),
`endif
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // behavioural model of the output stage
  logic              m_valid;
  logic [3:0]        m_gray;
  logic [ID_W-1:0]   m_id;
  int                m_last;
  logic [CNT_W-1:0]  m_cnt;
  int                n_acc;
  logic [N_REQ-1:0]  last_acc;
  logic [ID_W+3:0]   exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic int model_grant(input logic [N_REQ-1:0] elig, input int last);
    for (int k = 1; k <= N_REQ; k++)
      if (elig[(last + k) % N_REQ]) return (last + k) % N_REQ;
    return -1;
  endfunction

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_gray = '0; m_id = '0; m_last = N_REQ - 1;
    m_cnt = '0; n_acc = 0; last_acc = '0;
    exp_q.delete();
  endtask

  // One cycle: entered at negedge with inputs set; compares, advances the model, returns at next negedge.
  task automatic step();
    logic [N_REQ-1:0] elig, m_rdy;
    logic [3:0]       b;
    logic [ID_W+3:0]  front;
    int               g;
    bit               drain;
    #1;
    elig = req_valid;
`ifdef CONV_4_GRAY_ARB_PARITY_EN
    elig = elig & ~req_mask;
`endif
    g = model_grant(elig, m_last);
    m_rdy = '0;
    if ((!m_valid || out_ready) && g >= 0) m_rdy[g] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(m_rdy));
    chk("out_valid", 32'(out_valid), 32'(m_valid));
    chk("out_gray",  32'(out_gray),  32'(m_gray));
    chk("out_id",    32'(out_id),    32'(m_id));
    chk("xfer_cnt",  32'(xfer_cnt),  32'(m_cnt));
`ifdef CONV_4_GRAY_ARB_PARITY_EN
    chk("out_par", 32'(out_par), 32'(^m_gray));
    if (req_mask[1]) chk("masked_req1_ready", 32'(req_ready[1]), 32'd0);
`endif
    drain = m_valid && out_ready;
    if (drain) begin
      if (exp_q.size() == 0) fail_now("sb_underflow");
      else begin
        front = exp_q.pop_front();
        chk("sb_word", 32'({out_id, out_gray}), 32'(front));
      end
    end
    @(posedge clk);
    last_acc = m_rdy & req_valid;
    if (drain) begin m_cnt = m_cnt + 1'b1; m_valid = 1'b0; end
    if (m_rdy != 0) begin
      b = req_bin[g*4 +: 4];
      m_gray = to_gray(b); m_id = ID_W'(g); m_last = g; m_valid = 1'b1;
      exp_q.push_back({ID_W'(g), m_gray});
      n_acc++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req_valid = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [3:0] t3_gray [5];
  int         t3_id   [5];
  bit         pend    [N_REQ];
  logic [3:0] pbin    [N_REQ];
  int         budget;

  initial begin
    rst = 1'b1; req_valid = '0; req_bin = '0; out_ready = 1'b0;
`ifdef CONV_4_GRAY_ARB_PARITY_EN
    req_mask = '0;
`endif
    model_reset();
    // reset values held while rst is high, even with requests present
    @(negedge clk);
    req_valid = 4'b1111;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_gray",  32'(out_gray),  32'd0);
    chk("rst_out_id",    32'(out_id),    32'd0);
    chk("rst_xfer_cnt",  32'(xfer_cnt),  32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0; req_valid = '0;
    model_reset();

    // T2: single requester
    req_valid = 4'b0001; req_bin = 16'h000B; out_ready = 1'b1;
    #1;
    chk("t2_req_ready", 32'(req_ready), 32'b0001);
    step();
    chk("t2_out_gray", 32'(out_gray), 32'b1110);
    chk("t2_out_id",   32'(out_id),   32'd0);
    req_valid = '0;
    step();

    // T3: round robin across four always-valid requesters
    do_reset();
    t3_gray = '{4'b0000, 4'b0111, 4'b1111, 4'b1000, 4'b0000};
    t3_id   = '{0, 1, 2, 3, 0};
    req_valid = 4'b1111; req_bin = {4'd15, 4'd10, 4'd5, 4'd0}; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_out_id",   32'(out_id),   32'(t3_id[i]));
      chk("t3_out_gray", 32'(out_gray), 32'(t3_gray[i]));
    end
    req_valid = '0;
    step();

    // T4: backpressure holds the stage and blocks new grants
    req_valid = 4'b0001; req_bin = 16'h0003; out_ready = 1'b1;
    step();
    req_valid = 4'b0010; req_bin = 16'h0070; out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4_req_ready", 32'(req_ready), 32'd0);
      step();
      chk("t4_out_gray", 32'(out_gray), 32'b0010);
      chk("t4_out_id",   32'(out_id),   32'd0);
      chk("t4_out_valid", 32'(out_valid), 32'd1);
    end
    budget = int'(m_cnt);
    out_ready = 1'b1;
    step();
    chk("t4_drain_cnt", 32'(xfer_cnt), 32'(budget + 1));
    chk("t4_refill_id", 32'(out_id), 32'd1);
    req_valid = '0;
    step();

    // T1: asynchronous reset while the stage is full
    req_valid = 4'b0001; req_bin = 16'h0009; out_ready = 1'b0;
    step();
    chk("t1_pre_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("t1_out_valid", 32'(out_valid), 32'd0);
    chk("t1_xfer_cnt",  32'(xfer_cnt),  32'd0);
    chk("t1_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; req_valid = '0;
    model_reset();

    // T5: every requester, every bin, random backpressure
    for (int r = 0; r < N_REQ; r++) begin
      for (int b = 0; b < 16; b++) begin
        req_valid = '0; req_valid[r] = 1'b1;
        req_bin = '0; req_bin[r*4 +: 4] = 4'(b);
        budget = 0;
        do begin
          out_ready = 1'($urandom_range(0, 1));
          step();
          budget++;
        end while (!last_acc[r] && budget < 50);
        if (!last_acc[r]) fail_now("t5_accept_timeout");
      end
    end

    // randomized concurrent traffic; requesters hold until accepted
    for (int r = 0; r < N_REQ; r++) pend[r] = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int r = 0; r < N_REQ; r++) begin
        if (!pend[r] && $urandom_range(0, 1) == 1) begin
          pend[r] = 1'b1;
          pbin[r] = 4'($urandom_range(0, 15));
        end
        req_valid[r] = pend[r];
        req_bin[r*4 +: 4] = pend[r] ? pbin[r] : 4'($urandom_range(0, 15));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      step();
      for (int r = 0; r < N_REQ; r++) if (last_acc[r]) pend[r] = 1'b0;
    end

`ifdef CONV_4_GRAY_ARB_PARITY_EN
    // T6: requester 1 masked out
    req_mask = 4'b0010;
    req_valid = 4'b1111;
    for (int c = 0; c < 200; c++) begin
      req_bin = 16'($urandom_range(0, 65535));
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (last_acc[1]) fail_now("t6_masked_granted");
    end
    req_mask = '0;
`endif

    // drain what is left and reconcile counts
    req_valid = '0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("sb_empty",        32'(exp_q.size()), 32'd0);
    chk("xfer_cnt_total",  32'(xfer_cnt),     32'(n_acc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
